keypad_digit_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row returns, and decodes each new key press into a hex digit. Keeps the two most recent digits as `s0` (newest) and `s1` (previous) and feeds them directly to the dual seven-segment display multiplexer, replacing the DIP-switch inputs. Runs on the same 12 MHz HSOSC clock as the display stage.

---
 rtl/keypad_digit_scanner.sv | 160 ++++++++++++++++
 tb/tb_keypad_digit_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronizes and debounces row returns,
// decodes each fresh single-key press to a hex digit and keeps the last two digits.
module keypad_digit_scanner #(
    parameter int SCAN_TICKS     = 12_000,
    parameter int DEBOUNCE_TICKS = 240_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int CW        = $clog2(MAX_TICKS);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);

    // Digit table, one nibble per key, indexed by {row, column}.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t          state_reg;
    logic [3:0]      rows_meta_reg;
    logic [3:0]      rs_reg;
    logic [3:0]      rp_reg;
    logic [1:0]      ci_reg;
    logic [3:0]      cols_reg;
    logic [CW-1:0]   dwell_reg;
    logic [CW-1:0]   deb_reg;
    logic [3:0]      s0_reg;
    logic [3:0]      s1_reg;
    logic            key_valid_reg;
    logic            key_held_reg;

    logic [3:0]      row_low;
    logic            single_key;
    logic [1:0]      row_idx;
    logic [5:0]      key_bit;
    logic [3:0]      key_code;
    logic [1:0]      ci_next;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    always_comb begin
        row_low    = ~rp_reg;
        single_key = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
        row_idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row_low[i]) begin
                row_idx = 2'(i);
            end
        end
        key_bit  = {row_idx, ci_reg, 2'b00};
        key_code = KEY_MAP[key_bit +: 4];
        ci_next  = ci_reg + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_SCAN;
            rows_meta_reg <= 4'hF;
            rs_reg        <= 4'hF;
            rp_reg        <= 4'hF;
            ci_reg        <= 2'd0;
            cols_reg      <= 4'b1110;
            dwell_reg     <= '0;
            deb_reg       <= '0;
            s0_reg        <= 4'h0;
            s1_reg        <= 4'h0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            rows_meta_reg <= rows;
            rs_reg        <= rows_meta_reg;
            key_valid_reg <= 1'b0;

            case (state_reg)
                ST_SCAN: begin
                    if (dwell_reg == SCAN_LAST) begin
                        if (rs_reg != 4'hF) begin
                            rp_reg    <= rs_reg;
                            deb_reg   <= '0;
                            state_reg <= ST_DEBOUNCE;
                        end else begin
                            ci_reg    <= ci_next;
                            cols_reg  <= col_drive(ci_next);
                            dwell_reg <= '0;
                        end
                    end else begin
                        dwell_reg <= dwell_reg + CW'(1);
                    end
                end

                ST_DEBOUNCE: begin
                    if (rs_reg != rp_reg) begin
                        // Bounce: give up on this column and move on.
                        state_reg <= ST_SCAN;
                        ci_reg    <= ci_next;
                        cols_reg  <= col_drive(ci_next);
                        dwell_reg <= '0;
                    end else if (deb_reg == DEB_LAST) begin
                        state_reg    <= ST_HELD;
                        key_held_reg <= 1'b1;
                        if (single_key) begin
                            s1_reg        <= s0_reg;
                            s0_reg        <= key_code;
                            key_valid_reg <= 1'b1;
                        end
                    end else begin
                        deb_reg <= deb_reg + CW'(1);
                    end
                end

                ST_HELD: begin
                    if (rs_reg == 4'hF) begin
                        deb_reg   <= '0;
                        state_reg <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (rs_reg != 4'hF) begin
                        state_reg <= ST_HELD;
                    end else if (deb_reg == DEB_LAST) begin
                        state_reg    <= ST_SCAN;
                        key_held_reg <= 1'b0;
                        ci_reg       <= ci_next;
                        cols_reg     <= col_drive(ci_next);
                        dwell_reg    <= '0;
                    end else begin
                        deb_reg <= deb_reg + CW'(1);
                    end
                end

                default: begin
                    state_reg <= ST_SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_reg;
    assign s0        = s0_reg;
    assign s1        = s1_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Testbench for keypad_digit_scanner: a keypad matrix model drives the rows, and
// each accepted press is scored against a digit table and a two-deep history.
module tb_keypad_digit_scanner;

    localparam int SCAN    = 4;
    localparam int DEB     = 8;
    localparam int LAT_MAX = 2 + 4 * SCAN + DEB + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];
    logic [3:0] keymap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    logic       prev_held = 1'b0;
    logic [3:0] exp_s0 = 4'h0;
    logic [3:0] exp_s1 = 4'h0;

    keypad_digit_scanner #(
        .SCAN_TICKS    (SCAN),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .s0       (s0),
        .s1       (s1),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] === 1'b1 && cols[c] === 1'b0) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (key_valid === 1'b1) begin
            pulses++;
            check("valid_with_held", key_held, 1);
            check("held_rises_with_valid", prev_held, 0);
            $display("accept #%0d s0=%h s1=%h", pulses, s0, s1);
        end
        check("cols_one_low", $countones(~cols), 1);
        prev_held = key_held;
    endtask

    task automatic wait_valid(input string tag);
        int start;
        int lat;
        start = pulses;
        lat = 0;
        while (pulses == start && lat < LAT_MAX + 10) begin
            step();
            lat++;
        end
        check({tag, "_pulse"}, pulses - start, 1);
        check({tag, "_latency_ok"}, (lat <= LAT_MAX), 1);
    endtask

    task automatic wait_release(input string tag);
        int n;
        int start;
        start = pulses;
        n = 0;
        while (key_held !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_released"}, key_held, 0);
        check({tag, "_no_pulse_on_release"}, pulses - start, 0);
        check({tag, "_s0_kept"}, s0, exp_s0);
    endtask

    task automatic press_key(input int r, input int c, input int hold, input string tag);
        logic [3:0] col_exp;
        int start;
        pressed[r][c] = 1'b1;
        wait_valid(tag);
        exp_s1 = exp_s0;
        exp_s0 = keymap[r][c];
        check({tag, "_s0"}, s0, exp_s0);
        check({tag, "_s1"}, s1, exp_s1);
        start = pulses;
        repeat (hold) step();
        col_exp = ~(4'b0001 << c);
        check({tag, "_no_repeat"}, pulses - start, 0);
        check({tag, "_held"}, key_held, 1);
        check({tag, "_cols_frozen"}, cols, col_exp);
        pressed[r][c] = 1'b0;
        wait_release(tag);
        $display("key r%0d c%0d -> s0=%h s1=%h", r, c, s0, s1);
    endtask

    initial begin
        logic [3:0] col_exp;
        int base;
        int rr;
        int cc;

        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cols", cols, 4'b1110);
        check("rst_s0", s0, 0);
        check("rst_s1", s1, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        reset = 1'b0;

        // Idle rotation: one column every SCAN cycles
        for (int k = 1; k <= 20; k++) begin
            step();
            col_exp = ~(4'b0001 << ((k / SCAN) % 4));
            check("idle_cols", cols, col_exp);
            check("idle_valid", key_valid, 0);
            check("idle_held", key_held, 0);
        end
        $display("idle rotation done");

        // Three directed presses
        base = pulses;
        press_key(1, 2, 15, "k6");
        press_key(3, 1, 6, "k0");
        press_key(0, 3, 6, "kA");
        check("three_pulses", pulses - base, 3);

        // Bounce at onset and at release of (r2,c0)
        base = pulses;
        pressed[2][0] = 1'b1; step();
        pressed[2][0] = 1'b0; step();
        pressed[2][0] = 1'b1; step();
        pressed[2][0] = 1'b0; step();
        pressed[2][0] = 1'b1;
        wait_valid("bounce");
        exp_s1 = exp_s0;
        exp_s0 = keymap[2][0];
        check("bounce_s0", s0, exp_s0);
        check("bounce_s1", s1, exp_s1);
        repeat (10) step();
        pressed[2][0] = 1'b0; step();
        pressed[2][0] = 1'b1; step();
        pressed[2][0] = 1'b0; step();
        pressed[2][0] = 1'b1; step();
        pressed[2][0] = 1'b0;
        wait_release("bounce");
        check("bounce_single_pulse", pulses - base, 1);
        $display("bounce key -> s0=%h s1=%h", s0, s1);

        // Two keys in the same column: no digit, but held until both go up
        base = pulses;
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        repeat (40) step();
        check("multi_no_pulse", pulses - base, 0);
        check("multi_held", key_held, 1);
        check("multi_cols", cols, 4'b1101);
        check("multi_s0", s0, exp_s0);
        check("multi_s1", s1, exp_s1);
        pressed[0][1] = 1'b0;
        pressed[2][1] = 1'b0;
        wait_release("multi");
        $display("multi-key -> ignored s0=%h s1=%h", s0, s1);

        // Second key in another column while one is held is never seen
        pressed[0][0] = 1'b1;
        wait_valid("ghost_first");
        exp_s1 = exp_s0;
        exp_s0 = keymap[0][0];
        check("ghost_first_s0", s0, exp_s0);
        base = pulses;
        pressed[1][3] = 1'b1;
        repeat (30) step();
        check("ghost_no_pulse", pulses - base, 0);
        check("ghost_cols", cols, 4'b1110);
        check("ghost_s0", s0, exp_s0);
        pressed[0][0] = 1'b0;
        pressed[1][3] = 1'b0;
        wait_release("ghost");
        $display("ghost key -> ignored s0=%h s1=%h", s0, s1);

        // Random keys against the digit table and history model
        for (int n = 0; n < 8; n++) begin
            rr = int'($urandom_range(0, 3));
            cc = int'($urandom_range(0, 3));
            press_key(rr, cc, int'($urandom_range(2, 20)), "rand");
        end

        // Reset while a key is held; the key is then re-accepted as new
        pressed[1][1] = 1'b1;
        wait_valid("pre_reset");
        exp_s1 = exp_s0;
        exp_s0 = keymap[1][1];
        check("pre_reset_s0", s0, 4'h5);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_s0", s0, 0);
        check("mid_rst_s1", s1, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_cols", cols, 4'b1110);
        exp_s0 = 4'h0;
        exp_s1 = 4'h0;
        wait_valid("after_reset");
        exp_s1 = exp_s0;
        exp_s0 = keymap[1][1];
        check("after_reset_s0", s0, exp_s0);
        check("after_reset_s1", s1, exp_s1);
        pressed[1][1] = 1'b0;
        wait_release("after_reset");
        $display("reset re-detect -> s0=%h s1=%h", s0, s1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
